// File: rtl/fpu_pkg.sv
// Shared fp32 multiplier constants and the payload carried from the normalize stage to the round stage.
package fpu_pkg;

    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int ESUM_WIDTH = EXP_WIDTH + 2;
    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef struct packed {
        logic                         sign;
        logic signed [ESUM_WIDTH-1:0] e;
        logic [MANT_WIDTH-1:0]        m;
        logic                         g;
        logic                         s;
        logic                         nan;
        logic                         inf;
        logic                         zero;
    } s1_payload_t;

endpackage

// File: rtl/fpmul_round.sv
// Round stage datapath: RNE increment, carry into the exponent, range clamp and special-operand muxing.
// Macro FPMUL_FLAGS_EN adds out_flags = {invalid, overflow, underflow, inexact}.
module fpmul_round
    import fpu_pkg::*;
(
    input  logic                  in_sign,
    input  logic [ESUM_WIDTH-1:0] in_e,
    input  logic [MANT_WIDTH-1:0] in_m,
    input  logic                  in_g,
    input  logic                  in_s,
    input  logic                  in_nan,
    input  logic                  in_inf,
    input  logic                  in_zero,
    output logic [31:0]           out_result
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]            out_flags
`endif
);

    logic                         up;
    logic [MANT_WIDTH:0]          m_sum;
    logic signed [ESUM_WIDTH-1:0] e_adj;
    logic                         ovf;
    logic                         udf;

    always_comb begin
        up    = in_g & (in_s | in_m[0]);
        // On carry-out the low MANT_WIDTH bits are already zero, so no explicit clear is needed.
        m_sum = {1'b0, in_m} + {{MANT_WIDTH{1'b0}}, up};
        e_adj = in_e + {{(ESUM_WIDTH-1){1'b0}}, m_sum[MANT_WIDTH]};
        ovf   = int'(e_adj) >= EXP_MAX;
        udf   = int'(e_adj) <= 0;

        if (in_nan) begin
            out_result = QNAN;
        end else if (in_inf) begin
            out_result = PINF | {in_sign, 31'b0};
        end else if (in_zero) begin
            out_result = {in_sign, 31'b0};
        end else if (ovf) begin
            out_result = PINF | {in_sign, 31'b0};
        end else if (udf) begin
            out_result = {in_sign, 31'b0};
        end else begin
            out_result = {in_sign, e_adj[EXP_WIDTH-1:0], m_sum[MANT_WIDTH-1:0]};
        end
    end

`ifdef FPMUL_FLAGS_EN
    logic normal;

    always_comb begin
        normal    = ~in_nan & ~in_inf & ~in_zero;
        out_flags = {in_nan,
                     normal & ovf,
                     normal & udf,
                     normal & (in_g | in_s | ovf | udf)};
    end
`endif

endmodule

// File: rtl/fpmul_norm_round.sv
// fp32 multiplier back end: S1 normalizes the mantissa product, S2 rounds it and registers the packed result.
// Macro FPMUL_FLAGS_EN adds out_flags[3:0] aligned with out_result.
module fpmul_norm_round #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int ESUM_WIDTH = EXP_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [ESUM_WIDTH-1:0]         in_exp_sum,
    input  logic [2*(MANT_WIDTH+1)-1:0]   in_mant_prod,
    input  logic                          in_is_nan,
    input  logic                          in_is_inf,
    input  logic                          in_is_zero,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_result
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]                    out_flags
`endif
);

    import fpu_pkg::*;

    localparam int PROD_W = 2 * (MANT_WIDTH + 1);

    s1_payload_t norm;
    s1_payload_t s1_d, s1_q;
    logic        s1_v_d, s1_v_q;
    logic        s2_v_d, s2_v_q;
    logic [31:0] res_d, res_q;
    logic [31:0] round_result;
    logic        en1, en2;

    always_comb begin
        en2 = ~s2_v_q | out_ready;
        en1 = ~s1_v_q | en2;

        norm      = '0;
        norm.sign = in_sign;
        norm.nan  = in_is_nan;
        norm.inf  = in_is_inf;
        norm.zero = in_is_zero;
        // Product lies in [1,4): bit PROD_W-1 set means one extra integer bit to shift out.
        if (in_mant_prod[PROD_W-1]) begin
            norm.m = in_mant_prod[PROD_W-2 -: MANT_WIDTH];
            norm.g = in_mant_prod[PROD_W-MANT_WIDTH-2];
            norm.s = |in_mant_prod[PROD_W-MANT_WIDTH-3:0];
            norm.e = in_exp_sum + ESUM_WIDTH'(1);
        end else begin
            norm.m = in_mant_prod[PROD_W-3 -: MANT_WIDTH];
            norm.g = in_mant_prod[PROD_W-MANT_WIDTH-3];
            norm.s = |in_mant_prod[PROD_W-MANT_WIDTH-4:0];
            norm.e = in_exp_sum;
        end

        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (en1) begin
            s1_v_d = in_valid;
            if (in_valid) s1_d = norm;
        end

        s2_v_d = s2_v_q;
        res_d  = res_q;
        if (en2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) res_d = round_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
            s2_v_q <= 1'b0;
            res_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s1_q   <= s1_d;
            s2_v_q <= s2_v_d;
            res_q  <= res_d;
        end
    end

`ifdef FPMUL_FLAGS_EN
    logic [3:0] round_flags;
    logic [3:0] flags_d, flags_q;

    always_comb begin
        flags_d = flags_q;
        if (en2 && s1_v_q) flags_d = round_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign out_flags = flags_q;
`endif

    fpmul_round u_round (
        .in_sign    (s1_q.sign),
        .in_e       (s1_q.e),
        .in_m       (s1_q.m),
        .in_g       (s1_q.g),
        .in_s       (s1_q.s),
        .in_nan     (s1_q.nan),
        .in_inf     (s1_q.inf),
        .in_zero    (s1_q.zero),
        .out_result (round_result)
`ifdef FPMUL_FLAGS_EN
        ,
        .out_flags  (round_flags)
`endif
    );

    assign in_ready   = en1;
    assign out_valid  = s2_v_q;
    assign out_result = res_q;

endmodule

// File: tb/tb_fpmul_norm_round.sv
// Self-checking bench for fpmul_norm_round: scoreboard of expected results fed by the driver, drained by the consumer.
// Flag checks are compiled in when FPMUL_FLAGS_EN is defined.
module tb_fpmul_norm_round;

    typedef struct {
        logic        sign;
        int          esum;
        logic [47:0] prod;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] exp_res;
        logic [3:0]  exp_fl;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp_sum;
    logic [47:0] in_mant_prod;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    fpmul_norm_round #(.EXP_WIDTH(8), .MANT_WIDTH(23), .ESUM_WIDTH(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp_sum   (in_exp_sum),
        .in_mant_prod (in_mant_prod),
        .in_is_nan    (in_is_nan),
        .in_is_inf    (in_is_inf),
        .in_is_zero   (in_is_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result)
`ifdef FPMUL_FLAGS_EN
        ,
        .out_flags    (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: shift-and-compare rounding on the full product, independent of the g/s formulation.
    function automatic logic [31:0] model(input logic sign, input int esum, input logic [47:0] prod,
                                          input logic nan, input logic inf, input logic zero,
                                          output logic [3:0] fl);
        int          e;
        int          sh;
        logic [24:0] kept;
        logic [47:0] rem;
        logic [47:0] half;
        logic        up;
        fl = 4'b0000;
        if (nan) begin
            fl[3] = 1'b1;
            return 32'h7FC0_0000;
        end
        if (inf)  return {sign, 31'h7F80_0000};
        if (zero) return {sign, 31'h0};
        sh   = prod[47] ? 24 : 23;
        kept = 25'(prod >> sh);
        rem  = prod & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        e    = esum + (prod[47] ? 1 : 0);
        up   = (rem > half) || ((rem == half) && kept[0]);
        kept = kept + 25'(up);
        if (kept[24]) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        fl[0] = (rem != 0);
        if (e >= 255) begin
            fl[2] = 1'b1;
            fl[0] = 1'b1;
            return {sign, 31'h7F80_0000};
        end
        if (e <= 0) begin
            fl[1] = 1'b1;
            fl[0] = 1'b1;
            return {sign, 31'h0};
        end
        return {sign, e[7:0], kept[22:0]};
    endfunction

    function automatic beat_t make_beat(input logic sign, input int esum, input logic [47:0] prod,
                                        input logic nan, input logic inf, input logic zero);
        beat_t      b;
        logic [3:0] fl;
        b.sign    = sign;
        b.esum    = esum;
        b.prod    = prod;
        b.nan     = nan;
        b.inf     = inf;
        b.zero    = zero;
        b.exp_res = model(sign, esum, prod, nan, inf, zero, fl);
        b.exp_fl  = fl;
        return b;
    endfunction

    task automatic apply(input beat_t b);
        in_valid     = 1'b1;
        in_sign      = b.sign;
        in_exp_sum   = 10'(b.esum);
        in_mant_prod = b.prod;
        in_is_nan    = b.nan;
        in_is_inf    = b.inf;
        in_is_zero   = b.zero;
    endtask

    // Offers one beat from the next falling edge and returns after the rising edge that takes it.
    task automatic send_beat(input beat_t b);
        int unsigned n = 0;
        @(negedge clk);
        apply(b);
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        exp_q.push_back(b);
        @(posedge clk);
    endtask

    task automatic test_reset;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        n_checks++;
        if (out_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_result: got %h expected 00000000", out_result);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_latency;
        beat_t b;
        b = make_beat(1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        apply(b);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_cycle1_valid: got %0b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4010_0000) begin
            n_fail++;
            $display("FAIL latency_cycle2: valid=%0b result=%h expected valid=1 result=40100000",
                     out_valid, out_result);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_single_output: got valid %0b expected 0", out_valid);
        end
    endtask

    task automatic test_directed;
        beat_t vec[$];
        beat_t b;
        beat_t e;
        int    got = 0;
        int    n   = 0;
        b = make_beat(1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h4010_0000; vec.push_back(b);
        b = make_beat(1'b0, 127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h3F80_0000; vec.push_back(b);
        b = make_beat(1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h3F80_0002; vec.push_back(b);
        b = make_beat(1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h4000_0000; b.exp_fl = 4'b0001; vec.push_back(b);
        b = make_beat(1'b0, 254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h7F80_0000; b.exp_fl = 4'b0101; vec.push_back(b);
        b = make_beat(1'b1, 0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0); b.exp_res = 32'h8000_0000; b.exp_fl = 4'b0011; vec.push_back(b);
        b = make_beat(1'b1, 200, 48'hA5A5_5A5A_1234, 1'b1, 1'b1, 1'b1); b.exp_res = 32'h7FC0_0000; b.exp_fl = 4'b1000; vec.push_back(b);
        b = make_beat(1'b1, 5,   48'h4000_0000_0000, 1'b0, 1'b1, 1'b1); b.exp_res = 32'hFF80_0000; b.exp_fl = 4'b0000; vec.push_back(b);
        b = make_beat(1'b1, 300, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1); b.exp_res = 32'h8000_0000; b.exp_fl = 4'b0000; vec.push_back(b);
        fork
            begin
                foreach (vec[i]) send_beat(vec[i]);
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (got < vec.size() && n < 200) begin
                    @(negedge clk);
                    out_ready = 1'b1;
                    #1;
                    n++;
                    if (out_valid && out_ready) begin
                        e = exp_q.pop_front();
                        n_checks++;
                        if (out_result !== e.exp_res) begin
                            n_fail++;
                            $display("FAIL directed_result[%0d]: got %h expected %h", got, out_result, e.exp_res);
                        end
`ifdef FPMUL_FLAGS_EN
                        n_checks++;
                        if (out_flags !== e.exp_fl) begin
                            n_fail++;
                            $display("FAIL directed_flags[%0d]: got %b expected %b", got, out_flags, e.exp_fl);
                        end
`endif
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (got != vec.size()) begin
            n_fail++;
            $display("FAIL directed_count: got %0d results expected %0d", got, vec.size());
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 200;
        beat_t       b;
        beat_t       e;
        int          got = 0;
        int          n   = 0;
        logic [47:0] p;
        int unsigned r;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    p = {16'($urandom), $urandom};
                    if (!p[47]) p[46] = 1'b1;
                    r = $urandom_range(0, 15);
                    b = make_beat(1'($urandom), int'($urandom_range(0, 300)) - 40, p,
                                  r == 0 || r == 3, r == 1 || r == 3, r == 2 || r == 3);
                    send_beat(b);
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (got < N && n < 5000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    n++;
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_unexpected[%0d]: got %h expected no output", got, out_result);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_result !== e.exp_res) begin
                                n_fail++;
                                $display("FAIL b2b_result[%0d]: got %h expected %h", got, out_result, e.exp_res);
                            end
`ifdef FPMUL_FLAGS_EN
                            n_checks++;
                            if (out_flags !== e.exp_fl) begin
                                n_fail++;
                                $display("FAIL b2b_flags[%0d]: got %b expected %b", got, out_flags, e.exp_fl);
                            end
`endif
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        n_checks++;
        if (got != N || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results (%0d left) expected %0d", got, exp_q.size(), N);
        end
    endtask

    task automatic test_backpressure;
        beat_t       a, b, c, e;
        logic [31:0] held;
        int          n = 0;
        a = make_beat(1'b0, 100, 48'h8123_4567_89AB, 1'b0, 1'b0, 1'b0);
        b = make_beat(1'b1, 130, 48'h4ABC_DEF0_1234, 1'b0, 1'b0, 1'b0);
        c = make_beat(1'b0, 60,  48'hC000_0080_0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        apply(a);
        #1;
        if (in_ready) exp_q.push_back(a);
        @(negedge clk);
        apply(b);
        #1;
        if (in_ready) exp_q.push_back(b);
        @(negedge clk);
        apply(c);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%0b accepted=%0d expected in_ready=0 accepted=2", in_ready, exp_q.size());
        end
        held = out_result;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== held || out_result !== a.exp_res || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%0b result=%h in_ready=%0b expected valid=1 result=%h in_ready=0",
                     out_valid, out_result, in_ready, a.exp_res);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        if (in_ready) exp_q.push_back(c);
        while (exp_q.size() > 0 && n < 10) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_result !== e.exp_res) begin
                    n_fail++;
                    $display("FAIL bp_order: got %h expected %h", out_result, e.exp_res);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d results missing expected 0", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_duplicate: got valid %0b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        beat_t b;
        logic  seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        b = make_beat(1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        send_beat(b);
        send_beat(b);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: valid=%0b result=%h expected valid=0 result=00000000", out_valid, out_result);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_ready: got %0b expected 1", in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_discard: got an output after reset expected none");
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_sign      = 1'b0;
        in_exp_sum   = '0;
        in_mant_prod = '0;
        in_is_nan    = 1'b0;
        in_is_inf    = 1'b0;
        in_is_zero   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset;
        test_latency;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
